// File: rtl/cache_lru_nway.sv
// N-way set-associative read cache with true-LRU replacement and AHB-Lite whole-line refill.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters (o_hit_cnt, o_miss_cnt).
module cache_lru_nway #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        i_hclk,
    input  logic        i_hnreset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [29:0] i_req_addr,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    input  logic        i_nbypass,
    input  logic [31:0] i_climit,
    input  logic        i_flush,
    output logic [31:0] o_haddr,
    output logic [1:0]  o_htrans,
    output logic [2:0]  o_hburst,
    output logic [2:0]  o_hsize,
    input  logic        i_hready,
    input  logic        i_hresp,
    input  logic [31:0] i_hrdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
`endif
);

    localparam int unsigned OffW = $clog2(LINE_WORDS);
    localparam int unsigned IdxW = $clog2(SETS);
    localparam int unsigned TagW = 30 - OffW - IdxW;
    localparam int unsigned WayW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned CntW = OffW + 1;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [2:0] BurstSingle = 3'b000;
    localparam logic [2:0] BurstRefill = (LINE_WORDS == 4)  ? 3'b011 :
                                         (LINE_WORDS == 8)  ? 3'b101 :
                                         (LINE_WORDS == 16) ? 3'b111 : 3'b001;

    typedef enum logic [2:0] {StIdle, StLookup, StResp, StRefill, StBypass} state_e;

    logic [31:0]     data_q  [WAYS][SETS][LINE_WORDS];
    logic [TagW-1:0] tag_q   [WAYS][SETS];
    logic [WAYS-1:0] valid_q [SETS];
    logic [WayW-1:0] age_q   [SETS][WAYS];

    state_e          state_q, state_d;
    logic [29:0]     addr_q, addr_d;
    logic [WayW-1:0] victim_q, victim_d;
    logic [CntW-1:0] addr_cnt_q, addr_cnt_d;
    logic [OffW-1:0] data_cnt_q, data_cnt_d;
    logic            data_act_q, data_act_d;
    logic            flush_pend_q, flush_pend_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [OffW-1:0] off;
    logic [IdxW-1:0] idx;
    logic [TagW-1:0] tag;
    logic            uncached;
    logic            hit, inv_found;
    logic [WayW-1:0] hit_way, inv_way, old_way;

    logic            req_ready, flush_go, lru_upd, beat_we, line_done, inval;
    logic [WayW-1:0] lru_way;
    logic [1:0]      htrans;
    logic [31:0]     haddr;
    logic [2:0]      hburst;

    assign off      = addr_q[OffW-1:0];
    assign idx      = addr_q[OffW +: IdxW];
    assign tag      = addr_q[29 -: TagW];
    assign uncached = !i_nbypass || ({addr_q, 2'b00} >= i_climit);

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        old_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WayW'(w);
            end
            if (age_q[idx][w] == WayW'(WAYS - 1)) begin
                old_way = WayW'(w);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        victim_d     = victim_q;
        addr_cnt_d   = addr_cnt_q;
        data_cnt_d   = data_cnt_q;
        data_act_d   = data_act_q;
        flush_pend_d = flush_pend_q | i_flush;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = 1'b0;
        req_ready    = 1'b0;
        flush_go     = 1'b0;
        lru_upd      = 1'b0;
        lru_way      = '0;
        beat_we      = 1'b0;
        line_done    = 1'b0;
        inval        = 1'b0;
        htrans       = TransIdle;
        haddr        = '0;
        hburst       = BurstSingle;

        unique case (state_q)
            StIdle: begin
                if (flush_pend_q) begin
                    flush_go     = 1'b1;
                    flush_pend_d = i_flush;
                end else begin
                    req_ready = 1'b1;
                    if (i_req_valid) begin
                        addr_d  = i_req_addr;
                        state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                addr_cnt_d = '0;
                data_cnt_d = '0;
                data_act_d = 1'b0;
                if (uncached) begin
                    state_d = StBypass;
                end else if (hit) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = data_q[hit_way][idx][off];
                    lru_upd     = 1'b1;
                    lru_way     = hit_way;
                end else begin
                    state_d  = StRefill;
                    victim_d = inv_found ? inv_way : old_way;
                end
            end
            StRefill: begin
                hburst = BurstRefill;
                if (addr_cnt_q < CntW'(LINE_WORDS)) begin
                    htrans = (addr_cnt_q == '0) ? TransNonseq : TransSeq;
                    haddr  = {addr_q[29:OffW], addr_cnt_q[OffW-1:0], 2'b00};
                end
                if (data_act_q && i_hresp) begin
                    // First ERROR cycle: drop to IDLE next edge, discard the partial line.
                    inval       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = i_hrdata;
                    state_d     = StResp;
                end else if (i_hready) begin
                    data_act_d = (htrans != TransIdle);
                    if (htrans != TransIdle) begin
                        addr_cnt_d = addr_cnt_q + CntW'(1);
                    end
                    if (data_act_q) begin
                        beat_we    = 1'b1;
                        data_cnt_d = data_cnt_q + OffW'(1);
                        if (data_cnt_q == OffW'(LINE_WORDS - 1)) begin
                            line_done   = 1'b1;
                            lru_upd     = 1'b1;
                            lru_way     = victim_q;
                            rsp_valid_d = 1'b1;
                            rsp_data_d  = (off == OffW'(LINE_WORDS - 1)) ? i_hrdata :
                                          data_q[victim_q][idx][off];
                            state_d     = StResp;
                        end
                    end
                end
            end
            StBypass: begin
                if (addr_cnt_q == '0) begin
                    htrans = TransNonseq;
                    haddr  = {addr_q, 2'b00};
                end
                if (data_act_q && (i_hready || i_hresp)) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = i_hresp;
                    rsp_data_d  = i_hrdata;
                    state_d     = StResp;
                end else if (i_hready && (addr_cnt_q == '0)) begin
                    addr_cnt_d = CntW'(1);
                    data_act_d = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_hclk) begin
        if (!i_hnreset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            victim_q     <= '0;
            addr_cnt_q   <= '0;
            data_cnt_q   <= '0;
            data_act_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            victim_q     <= victim_d;
            addr_cnt_q   <= addr_cnt_d;
            data_cnt_q   <= data_cnt_d;
            data_act_q   <= data_act_d;
            flush_pend_q <= flush_pend_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (beat_we) begin
            data_q[victim_q][idx][data_cnt_q] <= i_hrdata;
        end
        if (line_done) begin
            tag_q[victim_q][idx] <= tag;
        end
    end

    always_ff @(posedge i_hclk) begin
        if (!i_hnreset || flush_go) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= WayW'(w);
                end
            end
        end else begin
            if (line_done) begin
                valid_q[idx][victim_q] <= 1'b1;
            end
            if (inval) begin
                valid_q[idx][victim_q] <= 1'b0;
            end
            if (lru_upd) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WayW'(w) == lru_way) begin
                        age_q[idx][w] <= '0;
                    end else if (age_q[idx][w] < age_q[idx][lru_way]) begin
                        age_q[idx][w] <= age_q[idx][w] + WayW'(1);
                    end
                end
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        cnt_hit, cnt_miss;

    assign cnt_hit  = (state_q == StLookup) && !uncached && hit;
    assign cnt_miss = (state_q == StLookup) && !uncached && !hit;

    always_ff @(posedge i_hclk) begin
        if (!i_hnreset || i_flush) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (cnt_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (cnt_miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign o_hit_cnt  = hit_cnt_q;
    assign o_miss_cnt = miss_cnt_q;
`endif

    // Reset forces the request and bus handshakes quiet without waiting for an edge.
    assign o_req_ready = req_ready & i_hnreset;
    assign o_htrans    = i_hnreset ? htrans : TransIdle;
    assign o_haddr     = haddr;
    assign o_hburst    = hburst;
    assign o_hsize     = 3'b010;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cache_lru_nway.sv
// Directed bench for cache_lru_nway (WAYS=4, SETS=16, LINE_WORDS=4) with a pipelined AHB slave model.
module tb_cache_lru_nway;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        nbypass;
    logic [31:0] climit;
    logic        flush;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // slave model state
    logic [31:0] log_addr[$];
    logic [1:0]  log_trans[$];
    logic [2:0]  log_burst[$];
    int          err_at     = -1;
    bit          slave_wait = 1'b0;
    int          trans_viol = 0;

    cache_lru_nway dut (
        .i_hclk      (clk),
        .i_hnreset   (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .i_nbypass   (nbypass),
        .i_climit    (climit),
        .i_flush     (flush),
        .o_haddr     (haddr),
        .o_htrans    (htrans),
        .o_hburst    (hburst),
        .o_hsize     (hsize),
        .i_hready    (hready),
        .i_hresp     (hresp),
        .i_hrdata    (hrdata)
`ifdef CACHE_STATS_EN
        ,
        .o_hit_cnt   (hit_cnt),
        .o_miss_cnt  (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Slave drives at negedge: first the data-phase reply, then samples the address phase.
    initial begin
        bit          dp_v, waited, err_p2;
        logic [31:0] dp_addr;
        int          dp_beat, beat;
        dp_v = 0; waited = 0; err_p2 = 0; dp_addr = '0; dp_beat = 0; beat = 0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dp_v = 0; waited = 0; err_p2 = 0;
                hready = 1'b1; hresp = 1'b0;
            end else begin
                if (err_p2) begin
                    hready = 1'b1; hresp = 1'b1;
                end else if (dp_v && dp_beat == err_at) begin
                    hready = 1'b0; hresp = 1'b1;
                end else if (dp_v && slave_wait && !waited) begin
                    hready = 1'b0; hresp = 1'b0; waited = 1;
                end else begin
                    hready = 1'b1; hresp = 1'b0; waited = 0;
                    hrdata = dp_v ? memval(dp_addr) : 32'h0;
                end
                if (hready) begin
                    if (err_p2) begin
                        if (htrans != 2'b00) trans_viol++;
                        err_p2 = 0;
                        dp_v   = 0;
                    end else if (htrans == 2'b10 || htrans == 2'b11) begin
                        beat = (htrans == 2'b10) ? 0 : beat + 1;
                        log_addr.push_back(haddr);
                        log_trans.push_back(htrans);
                        log_burst.push_back(hburst);
                        dp_v = 1; dp_addr = haddr; dp_beat = beat;
                    end else begin
                        dp_v = 0;
                    end
                end else if (hresp) begin
                    err_p2 = 1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_log();
        log_addr.delete();
        log_trans.delete();
        log_burst.delete();
    endtask

    task automatic do_read(input logic [31:0] baddr, output logic [31:0] data,
                           output logic err, output int lat);
        int guard;
        data = '0; err = 1'b0; lat = -1; guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = baddr[31:2];
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (guard < 100) begin
            for (int n = 1; n < 200; n++) begin
                if (rsp_valid) begin
                    data = rsp_data; err = rsp_err; lat = n;
                    break;
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
        nbypass = 1'b1; climit = 32'h1000; flush = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else n_pass++;
        n_checks++; if (htrans !== 2'b00) $display("FAIL reset_htrans: got %b want 00", htrans); else n_pass++;
        n_checks++; if (haddr !== 32'h0) $display("FAIL reset_haddr: got %h want 0", haddr); else n_pass++;
        n_checks++; if (hsize !== 3'b010) $display("FAIL hsize: got %b want 010", hsize); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_refill();
        logic [31:0] d; logic e; int lat;
        clear_log();
        do_read(32'h40, d, e, lat);
        n_checks++; if (d !== 32'hC0DE0040) $display("FAIL refill_data: got %h want C0DE0040", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL refill_err: got %b want 0", e); else n_pass++;
        n_checks++; if (lat !== 7) $display("FAIL refill_latency: got %0d want 7", lat); else n_pass++;
        n_checks++; if (log_addr.size() !== 4) $display("FAIL refill_beats: got %0d want 4", log_addr.size()); else n_pass++;
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== 32'h40 + 32'(i * 4))
                $display("FAIL refill_addr%0d: got %h want %h", i, log_addr[i], 32'h40 + 32'(i * 4));
            else n_pass++;
            n_checks++;
            if (log_trans[i] !== ((i == 0) ? 2'b10 : 2'b11))
                $display("FAIL refill_trans%0d: got %b want %b", i, log_trans[i], (i == 0) ? 2'b10 : 2'b11);
            else n_pass++;
        end
        if (log_burst.size() > 0) begin
            n_checks++; if (log_burst[0] !== 3'b011) $display("FAIL refill_hburst: got %b want 011", log_burst[0]); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rsp_pulse_width: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_hit();
        logic [31:0] d; logic e; int lat;
        clear_log();
        do_read(32'h44, d, e, lat);
        n_checks++; if (d !== 32'hC0DE0044) $display("FAIL hit_data: got %h want C0DE0044", d); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL hit_latency: got %0d want 2", lat); else n_pass++;
        do_read(32'h4C, d, e, lat);
        n_checks++; if (d !== 32'hC0DE004C) $display("FAIL hit_last_word: got %h want C0DE004C", d); else n_pass++;
        n_checks++; if (log_addr.size() !== 0) $display("FAIL hit_no_ahb: got %0d want 0 beats", log_addr.size()); else n_pass++;
    endtask

    task automatic test_lru();
        logic [31:0] d; logic e; int lat;
        // Lines 0x000..0x400 all map to set 0 (stride 0x100 bytes).
        for (int i = 0; i < 4; i++) do_read(32'(i * 256), d, e, lat);
        clear_log();
        do_read(32'h000, d, e, lat);
        n_checks++; if (lat !== 2) $display("FAIL lru_touch0_hit: got lat %0d want 2", lat); else n_pass++;
        do_read(32'h408, d, e, lat);
        n_checks++; if (d !== 32'hC0DE0408) $display("FAIL lru_fill4_data: got %h want C0DE0408", d); else n_pass++;
        n_checks++; if (log_addr.size() !== 4) $display("FAIL lru_fill4_miss: got %0d want 4 beats", log_addr.size()); else n_pass++;
        clear_log();
        do_read(32'h004, d, e, lat);
        n_checks++; if (lat !== 2) $display("FAIL lru_line0_kept: got lat %0d want 2", lat); else n_pass++;
        do_read(32'h100, d, e, lat);
        n_checks++; if (log_addr.size() !== 4) $display("FAIL lru_line1_evicted: got %0d want 4 beats", log_addr.size()); else n_pass++;
        clear_log();
        do_read(32'h400, d, e, lat);
        n_checks++; if (lat !== 2) $display("FAIL lru_line4_hit: got lat %0d want 2", lat); else n_pass++;
        do_read(32'h300, d, e, lat);
        n_checks++; if (lat !== 2) $display("FAIL lru_line3_hit: got lat %0d want 2", lat); else n_pass++;
        n_checks++; if (log_addr.size() !== 0) $display("FAIL lru_hits_no_ahb: got %0d want 0 beats", log_addr.size()); else n_pass++;
        do_read(32'h200, d, e, lat);
        n_checks++; if (log_addr.size() !== 4) $display("FAIL lru_line2_evicted: got %0d want 4 beats", log_addr.size()); else n_pass++;
    endtask

    task automatic test_bypass();
        logic [31:0] d; logic e; int lat;
        for (int k = 0; k < 2; k++) begin
            clear_log();
            do_read(32'h2000, d, e, lat);
            n_checks++; if (d !== 32'hC0DE2000) $display("FAIL byp_data%0d: got %h want C0DE2000", k, d); else n_pass++;
            n_checks++; if (log_addr.size() !== 1) $display("FAIL byp_single%0d: got %0d want 1 beat", k, log_addr.size()); else n_pass++;
            if (log_addr.size() == 1) begin
                n_checks++; if (log_addr[0] !== 32'h2000) $display("FAIL byp_addr%0d: got %h want 2000", k, log_addr[0]); else n_pass++;
                n_checks++; if (log_burst[0] !== 3'b000) $display("FAIL byp_hburst%0d: got %b want 000", k, log_burst[0]); else n_pass++;
                n_checks++; if (log_trans[0] !== 2'b10) $display("FAIL byp_trans%0d: got %b want 10", k, log_trans[0]); else n_pass++;
            end
        end
        n_checks++; if (lat !== 4) $display("FAIL byp_latency: got %0d want 4", lat); else n_pass++;
        clear_log();
        do_read(32'h1000, d, e, lat);
        n_checks++; if (log_addr.size() !== 1) $display("FAIL climit_edge_uncached: got %0d want 1 beat", log_addr.size()); else n_pass++;
        clear_log();
        do_read(32'h0FFC, d, e, lat);
        n_checks++; if (d !== 32'hC0DE0FFC) $display("FAIL below_climit_data: got %h want C0DE0FFC", d); else n_pass++;
        n_checks++; if (log_addr.size() !== 4) $display("FAIL below_climit_cached: got %0d want 4 beats", log_addr.size()); else n_pass++;
        if (log_addr.size() > 0) begin
            n_checks++; if (log_addr[0] !== 32'h0FF0) $display("FAIL below_climit_base: got %h want 0FF0", log_addr[0]); else n_pass++;
        end
        clear_log();
        nbypass = 1'b0;
        do_read(32'h44, d, e, lat);
        nbypass = 1'b1;
        n_checks++; if (log_addr.size() !== 1) $display("FAIL nbypass_single: got %0d want 1 beat", log_addr.size()); else n_pass++;
        n_checks++; if (d !== 32'hC0DE0044) $display("FAIL nbypass_data: got %h want C0DE0044", d); else n_pass++;
        do_read(32'h44, d, e, lat);
        n_checks++; if (lat !== 2) $display("FAIL nbypass_cache_kept: got lat %0d want 2", lat); else n_pass++;
    endtask

    task automatic test_error();
        logic [31:0] d; logic e; int lat;
        clear_log();
        trans_viol = 0;
        err_at = 2;
        do_read(32'h5C8, d, e, lat);
        err_at = -1;
        repeat (2) @(negedge clk);
        n_checks++; if (lat !== 6) $display("FAIL err_rsp_latency: got %0d want 6", lat); else n_pass++;
        n_checks++; if (e !== 1'b1) $display("FAIL err_flag: got %b want 1", e); else n_pass++;
        n_checks++; if (log_addr.size() !== 3) $display("FAIL err_beats_issued: got %0d want 3", log_addr.size()); else n_pass++;
        n_checks++; if (trans_viol !== 0) $display("FAIL err_htrans_idle: got %0d violations want 0", trans_viol); else n_pass++;
        clear_log();
        do_read(32'h5C8, d, e, lat);
        n_checks++; if (log_addr.size() !== 4) $display("FAIL err_refetch: got %0d want 4 beats", log_addr.size()); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL err_refetch_flag: got %b want 0", e); else n_pass++;
        n_checks++; if (d !== 32'hC0DE05C8) $display("FAIL err_refetch_data: got %h want C0DE05C8", d); else n_pass++;
    endtask

    task automatic test_flush();
        logic [31:0] d; logic e; int lat;
        clear_log();
        fork
            do_read(32'h600, d, e, lat);
            begin
                repeat (4) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join
        n_checks++; if (d !== 32'hC0DE0600) $display("FAIL flush_refill_data: got %h want C0DE0600", d); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL flush_refill_err: got %b want 0", e); else n_pass++;
        n_checks++; if (lat !== 7) $display("FAIL flush_refill_latency: got %0d want 7", lat); else n_pass++;
        clear_log();
        do_read(32'h600, d, e, lat);
        n_checks++; if (log_addr.size() !== 4) $display("FAIL flush_line_missed: got %0d want 4 beats", log_addr.size()); else n_pass++;
        clear_log();
        do_read(32'h44, d, e, lat);
        n_checks++; if (log_addr.size() !== 4) $display("FAIL flush_old_line_missed: got %0d want 4 beats", log_addr.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int lat;
        clear_log();
        slave_wait = 1'b1;
        do_read(32'h700, d, e, lat);
        slave_wait = 1'b0;
        n_checks++; if (lat !== 11) $display("FAIL wait_refill_latency: got %0d want 11", lat); else n_pass++;
        n_checks++; if (d !== 32'hC0DE0700) $display("FAIL wait_refill_data: got %h want C0DE0700", d); else n_pass++;
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== 32'h700 + 32'(i * 4))
                $display("FAIL wait_addr%0d: got %h want %h", i, log_addr[i], 32'h700 + 32'(i * 4));
            else n_pass++;
        end
        do_read(32'h704, d, e, lat);
        n_checks++; if (d !== 32'hC0DE0704 || lat !== 2) $display("FAIL b2b_hit1: got %h lat %0d want C0DE0704 lat 2", d, lat); else n_pass++;
        do_read(32'h70C, d, e, lat);
        n_checks++; if (d !== 32'hC0DE070C || lat !== 2) $display("FAIL b2b_hit2: got %h lat %0d want C0DE070C lat 2", d, lat); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d; logic e; int lat; int pulses; int guard;
        slave_wait = 1'b1;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 30'(32'h800 >> 2);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (htrans === 2'b00) $display("FAIL midburst_active: got htrans %b want non-idle", htrans); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++; if (htrans !== 2'b00) $display("FAIL midburst_rst_htrans: got %b want 00", htrans); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        slave_wait = 1'b0;
        pulses = 0;
        repeat (6) begin
            if (rsp_valid) pulses++;
            @(negedge clk);
        end
        n_checks++; if (pulses !== 0) $display("FAIL midburst_no_rsp: got %0d pulses want 0", pulses); else n_pass++;
        clear_log();
        do_read(32'h800, d, e, lat);
        n_checks++; if (log_addr.size() !== 4 || d !== 32'hC0DE0800)
            $display("FAIL midburst_refetch: got %0d beats data %h want 4 beats C0DE0800", log_addr.size(), d);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_refill();
        test_hit();
        test_lru();
        test_bypass();
        test_error();
        test_flush();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
